// File: rtl/tag_mac_scheduler_if.sv
// Bundles the scheduler's control, symbol-stream, reader-response and
// switch-gating signals; the scheduler uses the slave view.
interface tag_mac_scheduler_if;
   logic        start_pulse;
   logic [7:0]  frame_len;
   logic [19:0] channel_mask;
   logic [19:0] symbol_data;
   logic        symbol_valid;
   logic        symbol_ready;
   logic        ack_valid;
   logic        ack_in;
   logic        trigger_signal;
   logic [19:0] control_signal;
   logic [19:0] data_out;
   logic        frame_rewind;
   logic        busy;
   logic        tx_done;
   logic        tx_fail;

   modport master (
      output start_pulse, frame_len, channel_mask, symbol_data, symbol_valid,
             ack_valid, ack_in,
      input  symbol_ready, trigger_signal, control_signal, data_out,
             frame_rewind, busy, tx_done, tx_fail
   );

   modport slave (
      input  start_pulse, frame_len, channel_mask, symbol_data, symbol_valid,
             ack_valid, ack_in,
      output symbol_ready, trigger_signal, control_signal, data_out,
             frame_rewind, busy, tx_done, tx_fail
   );
endinterface

// File: rtl/tag_mac_scheduler.sv
// Random-access transmit scheduler: binary-exponential backoff, symbol-timed
// frame streaming onto the switch gating stage, ACK wait and retry.
module tag_mac_scheduler #(
   parameter int          SLOT_LEN    = 64,
   parameter int          SYM_LEN     = 16,
   parameter int          CW_MIN      = 4,
   parameter int          CW_MAX      = 64,
   parameter int          MAX_RETRY   = 3,
   parameter int          ACK_TIMEOUT = 1024,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic                 input_clock,
   input logic                 reset_n,
   tag_mac_scheduler_if.slave  bus
);
   localparam int BO_W   = $clog2(255 * SLOT_LEN + 1);
   localparam int HOLD_W = $clog2(SYM_LEN + 1);
   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BACKOFF, TX, WAIT_ACK} state_t;

   state_t            state, state_d;
   logic [15:0]       lfsr, lfsr_d;
   logic [8:0]        cw, cw_d, cw_next;
   logic [7:0]        attempt, attempt_d;
   logic [7:0]        len_q, len_d;
   logic [19:0]       mask_q, mask_d;
   logic [7:0]        words_left, words_d;
   logic [HOLD_W-1:0] hold_cnt, hold_d;
   logic [BO_W-1:0]   bo_cnt, bo_d;
   logic [WAIT_W-1:0] wait_cnt, wait_d;
   logic              trig_q, trig_d;
   logic [19:0]       ctrl_q, ctrl_d;
   logic [19:0]       data_q, data_d;
   logic              rewind_q, rewind_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic              busy_q;

   function automatic logic [BO_W-1:0] draw_backoff(input logic [7:0] rnd,
                                                    input logic [8:0] win);
      logic [7:0] slots;
      slots = rnd & 8'(win - 9'd1);
      return BO_W'(slots) * BO_W'(SLOT_LEN);
   endfunction

   // Window doubles until it saturates at CW_MAX.
   assign cw_next = (cw >= 9'(CW_MAX / 2)) ? 9'(CW_MAX) : {cw[7:0], 1'b0};

   assign bus.symbol_ready   = (state == TX) && (hold_cnt == '0) && (words_left != '0);
   assign bus.trigger_signal = trig_q;
   assign bus.control_signal = ctrl_q;
   assign bus.data_out       = data_q;
   assign bus.frame_rewind   = rewind_q;
   assign bus.busy           = busy_q;
   assign bus.tx_done        = done_q;
   assign bus.tx_fail        = fail_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
      state_d   = state;
      lfsr_d    = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      cw_d      = cw;
      attempt_d = attempt;
      len_d     = len_q;
      mask_d    = mask_q;
      words_d   = words_left;
      hold_d    = hold_cnt;
      bo_d      = bo_cnt;
      wait_d    = wait_cnt;
      trig_d    = trig_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      rewind_d  = 1'b0;
      done_d    = 1'b0;
      fail_d    = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.start_pulse) begin
               if (bus.frame_len == '0) begin
                  fail_d = 1'b1;
               end else begin
                  len_d     = bus.frame_len;
                  mask_d    = bus.channel_mask;
                  cw_d      = 9'(CW_MIN);
                  attempt_d = 8'd1;
                  bo_d      = draw_backoff(lfsr[7:0], 9'(CW_MIN));
                  state_d   = BACKOFF;
               end
            end
         end
         BACKOFF: begin
            if (bo_cnt == '0) begin
               state_d = TX;
               words_d = len_q;
               hold_d  = '0;
            end else begin
               bo_d = bo_cnt - BO_W'(1);
            end
         end
         TX: begin
            if (hold_cnt != '0) begin
               hold_d = hold_cnt - HOLD_W'(1);
            end else if (words_left != '0) begin
               if (bus.symbol_valid) begin
                  data_d  = bus.symbol_data;
                  trig_d  = 1'b1;
                  ctrl_d  = mask_q;
                  hold_d  = HOLD_W'(SYM_LEN - 1);
                  words_d = words_left - 8'd1;
               end else begin
                  // Underrun: drop to idle-clock mode but keep the switches enabled.
                  trig_d = 1'b0;
                  data_d = '0;
               end
            end else begin
               state_d = WAIT_ACK;
               trig_d  = 1'b0;
               ctrl_d  = '0;
               data_d  = '0;
               wait_d  = '0;
            end
         end
         WAIT_ACK: begin
            if (bus.ack_valid && bus.ack_in) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if ((bus.ack_valid && !bus.ack_in) ||
                         (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1))) begin
               if (attempt == 8'(MAX_RETRY)) begin
                  fail_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  attempt_d = attempt + 8'd1;
                  cw_d      = cw_next;
                  rewind_d  = 1'b1;
                  bo_d      = draw_backoff(lfsr[7:0], cw_next);
                  state_d   = BACKOFF;
               end
            end else begin
               wait_d = wait_cnt + WAIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge input_clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         cw         <= '0;
         attempt    <= '0;
         len_q      <= '0;
         mask_q     <= '0;
         words_left <= '0;
         hold_cnt   <= '0;
         bo_cnt     <= '0;
         wait_cnt   <= '0;
         trig_q     <= 1'b0;
         ctrl_q     <= '0;
         data_q     <= '0;
         rewind_q   <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_d;
         lfsr       <= lfsr_d;
         cw         <= cw_d;
         attempt    <= attempt_d;
         len_q      <= len_d;
         mask_q     <= mask_d;
         words_left <= words_d;
         hold_cnt   <= hold_d;
         bo_cnt     <= bo_d;
         wait_cnt   <= wait_d;
         trig_q     <= trig_d;
         ctrl_q     <= ctrl_d;
         data_q     <= data_d;
         rewind_q   <= rewind_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
         busy_q     <= (state_d != IDLE);
      end
   end
endmodule

// File: tb/tb_tag_mac_scheduler.sv
// Directed bench for tag_mac_scheduler: frame timing, retries, timeouts,
// underrun and edge cases, checked with immediate assertions.
module tb_tag_mac_scheduler;
   localparam logic [15:0] SEED   = 16'hACE1;
   localparam logic [19:0] W_BASE = 20'hC3A00;

   logic        input_clock = 1'b0;
   logic        reset_n;
   logic [15:0] m_lfsr;
   logic [7:0]  src_idx;
   logic [15:0] lf;
   int          tests = 0;
   int          fails = 0;
   int          n;

   tag_mac_scheduler_if bus();

   tag_mac_scheduler dut (
      .input_clock (input_clock),
      .reset_n     (reset_n),
      .bus         (bus)
   );

   always #5 input_clock = ~input_clock;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
   always @(posedge input_clock) begin
      if (!reset_n) m_lfsr <= SEED;
      else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   // Source FIFO stand-in: word i is W_BASE+i, replayed from 0 on rewind.
   always @(posedge input_clock) begin
      if (!reset_n || (bus.start_pulse && !bus.busy) || bus.frame_rewind) src_idx <= 8'd0;
      else if (bus.symbol_valid && bus.symbol_ready) src_idx <= src_idx + 8'd1;
   end
   assign bus.symbol_data = W_BASE + {12'd0, src_idx};

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge input_clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] len, input logic [19:0] mask,
                              output logic [15:0] lf_o);
      lf_o             = m_lfsr;
      bus.frame_len    = len;
      bus.channel_mask = mask;
      bus.start_pulse  = 1'b1;
      tick();
      bus.start_pulse  = 1'b0;
   endtask

   task automatic send_ack(input logic ok, output logic [15:0] lf_o);
      lf_o          = m_lfsr;
      bus.ack_valid = 1'b1;
      bus.ack_in    = ok;
      tick();
      bus.ack_valid = 1'b0;
      bus.ack_in    = 1'b0;
   endtask

   // From the edge that entered BACKOFF, the first word shows slots*64+2 cycles later.
   task automatic run_backoff(input string tag, input logic [15:0] lf_i, input logic [8:0] win);
      int          cnt;
      logic [7:0]  slots;
      slots = lf_i[7:0] & 8'(win - 9'd1);
      cnt   = 0;
      while (bus.trigger_signal !== 1'b1 && cnt < 20000) begin
         tick();
         cnt++;
      end
      check(tag, 32'(cnt), 32'(slots) * 32'd64 + 32'd2);
   endtask

   task automatic wait_frame_end(output int cnt);
      cnt = 0;
      while (bus.trigger_signal === 1'b1 && cnt < 5000) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_resolution(output int cnt, output logic [15:0] lf_o);
      cnt  = 0;
      lf_o = m_lfsr;
      while (!(bus.frame_rewind || bus.tx_fail || bus.tx_done) && cnt < 3000) begin
         lf_o = m_lfsr;
         tick();
         cnt++;
      end
   endtask

   initial begin
      reset_n          = 1'b0;
      bus.start_pulse  = 1'b0;
      bus.frame_len    = 8'd0;
      bus.channel_mask = 20'd0;
      bus.symbol_valid = 1'b1;
      bus.ack_valid    = 1'b0;
      bus.ack_in       = 1'b0;
      repeat (3) tick();

      check("rst_trigger", bus.trigger_signal, 0);
      check("rst_control", bus.control_signal, 0);
      check("rst_data",    bus.data_out, 0);
      check("rst_busy",    bus.busy, 0);
      check("rst_pulses",  {bus.tx_done, bus.tx_fail, bus.frame_rewind}, 0);
      check("rst_ready",   bus.symbol_ready, 0);
      reset_n = 1'b1;
      tick();
      check("idle_ready_ignores_valid", bus.symbol_ready, 0);

      // Basic frame with a zero-slot draw.
      n = 0;
      while (m_lfsr[1:0] != 2'b00 && n < 64) begin
         tick();
         n++;
      end
      start_frame(8'd3, 20'h000FF, lf);
      check("t1_busy_at_start", bus.busy, 1);
      tick();
      check("t1_trigger_before_first_word", bus.trigger_signal, 0);
      tick();
      for (int c = 0; c < 48; c++) begin
         check($sformatf("t1_data_c%0d", c), bus.data_out, 32'(W_BASE + 20'(c / 16)));
         check($sformatf("t1_trig_c%0d", c), bus.trigger_signal, 1);
         check($sformatf("t1_ctrl_c%0d", c), bus.control_signal, 32'h000FF);
         tick();
      end
      check("t1_trigger_fall", bus.trigger_signal, 0);
      check("t1_control_off",  bus.control_signal, 0);
      check("t1_data_off",     bus.data_out, 0);
      check("t1_busy_wait",    bus.busy, 1);
      send_ack(1'b1, lf);
      check("t1_tx_done", bus.tx_done, 1);
      check("t1_idle",    bus.busy, 0);
      tick();
      check("t1_tx_done_single", bus.tx_done, 0);

      // NACK, NACK, ACK with growing contention windows.
      start_frame(8'd2, 20'h0F0F0, lf);
      run_backoff("t2_backoff_cw4", lf, 9'd4);
      wait_frame_end(n);
      send_ack(1'b0, lf);
      check("t2_rewind1", bus.frame_rewind, 1);
      check("t2_nofail1", bus.tx_fail, 0);
      check("t2_busy1",   bus.busy, 1);
      run_backoff("t2_backoff_cw8", lf, 9'd8);
      check("t2_replay_w0", bus.data_out, 32'(W_BASE));
      wait_frame_end(n);
      send_ack(1'b0, lf);
      check("t2_rewind2", bus.frame_rewind, 1);
      run_backoff("t2_backoff_cw16", lf, 9'd16);
      wait_frame_end(n);
      send_ack(1'b1, lf);
      check("t2_tx_done", bus.tx_done, 1);
      check("t2_nofail",  bus.tx_fail, 0);
      check("t2_norewind", bus.frame_rewind, 0);

      // Three ACK timeouts.
      start_frame(8'd1, 20'hAAAAA, lf);
      for (int i = 1; i <= 3; i++) begin
         run_backoff($sformatf("t3_backoff_a%0d", i), lf, 9'(4 << (i - 1)));
         wait_frame_end(n);
         wait_resolution(n, lf);
         check($sformatf("t3_timeout_len_a%0d", i), 32'(n), 1024);
         if (i < 3) begin
            check($sformatf("t3_rewind_a%0d", i), bus.frame_rewind, 1);
            check($sformatf("t3_nofail_a%0d", i), bus.tx_fail, 0);
         end else begin
            check("t3_fail",        bus.tx_fail, 1);
            check("t3_no_rewind",   bus.frame_rewind, 0);
            check("t3_busy_clear",  bus.busy, 0);
         end
      end

      // Underrun between W0 and W1.
      start_frame(8'd2, 20'h12345, lf);
      run_backoff("t4_backoff", lf, 9'd4);
      check("t4_w0_head", bus.data_out, 32'(W_BASE));
      repeat (15) tick();
      check("t4_w0_tail", bus.data_out, 32'(W_BASE));
      bus.symbol_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("t4_ur_trig_c%0d", c), bus.trigger_signal, 0);
         check($sformatf("t4_ur_data_c%0d", c), bus.data_out, 0);
         check($sformatf("t4_ur_ctrl_c%0d", c), bus.control_signal, 32'h12345);
      end
      bus.symbol_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         tick();
         check($sformatf("t4_w1_data_c%0d", c), bus.data_out, 32'(W_BASE + 20'd1));
         check($sformatf("t4_w1_trig_c%0d", c), bus.trigger_signal, 1);
      end
      tick();
      check("t4_trigger_fall", bus.trigger_signal, 0);
      send_ack(1'b1, lf);
      check("t4_tx_done", bus.tx_done, 1);

      // Empty frame.
      start_frame(8'd0, 20'hFFFFF, lf);
      check("t5_fail_pulse", bus.tx_fail, 1);
      check("t5_not_busy",   bus.busy, 0);
      tick();
      check("t5_fail_single", bus.tx_fail, 0);
      check("t5_still_idle",  bus.busy, 0);

      // Start while transmitting is ignored.
      start_frame(8'd2, 20'h000F0, lf);
      run_backoff("t6_backoff", lf, 9'd4);
      repeat (3) tick();
      bus.frame_len    = 8'd5;
      bus.channel_mask = 20'hFFFFF;
      bus.start_pulse  = 1'b1;
      tick();
      bus.start_pulse  = 1'b0;
      check("t6_mask_kept", bus.control_signal, 32'h000F0);
      check("t6_busy",      bus.busy, 1);
      wait_frame_end(n);
      check("t6_frame_len_kept", 32'(n), 28);
      send_ack(1'b1, lf);
      check("t6_tx_done", bus.tx_done, 1);

      // Reset in the middle of a frame.
      start_frame(8'd3, 20'h0ABCD, lf);
      run_backoff("t7_backoff", lf, 9'd4);
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      check("t7_trigger", bus.trigger_signal, 0);
      check("t7_control", bus.control_signal, 0);
      check("t7_data",    bus.data_out, 0);
      check("t7_busy",    bus.busy, 0);
      check("t7_ready",   bus.symbol_ready, 0);
      reset_n = 1'b1;
      tick();

      // ACK arriving on the timeout cycle wins.
      start_frame(8'd1, 20'h00F00, lf);
      run_backoff("t8_backoff", lf, 9'd4);
      wait_frame_end(n);
      repeat (1023) tick();
      send_ack(1'b1, lf);
      check("t8_tx_done",   bus.tx_done, 1);
      check("t8_no_rewind", bus.frame_rewind, 0);
      check("t8_no_fail",   bus.tx_fail, 0);
      check("t8_idle",      bus.busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
